complex_butterfly_bfp: RTL and testbench
========================================

Name: complex_butterfly_bfp

Overview:
- Radix-2 DIT complex butterfly, fully pipelined at one sample per clock: dout1 = A + B*W, dout2 = A - B*W.
- Generalises the fixed-variant butterfly family with:
  - parametrised latency;
  - a per-sample scaling mode (none, fixed shift by 1 or 2, or automatic block-floating-point);
  - saturation;
  - a sticky growth detector;
  - a block-exponent counter for the iterative FFT controller.

Parameters:
- IWL1, 16, data word length (A, B), two's complement.
- IWL2, 16, twiddle word length; W is Q1.(IWL2-1).
- OWL, 16, output word length; must be >= IWL1.
- LATENCY, 4, strb_in-to-strb_out delay in clocks; legal range 3..8. Extra stages beyond 3 are output retiming registers.
- EXPW, 5, width of blk_exp.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- strb_in  in  1  input sample valid.
- mode  in  2  scaling mode, sampled with strb_in: 0 = no shift, 1 = >>1, 2 = >>2, 3 = auto.
- din1_re, din1_im  in  IWL1  B operand.
- din2_re, din2_im  in  IWL2  W twiddle.
- din3_re, din3_im  in  IWL1  A operand.
- stage_clr  in  1  end-of-stage pulse; updates the auto shift and blk_exp.
- frame_start  in  1  clears blk_exp.
- dout1_re, dout1_im, dout2_re, dout2_im  out  OWL  results.
- strb_out  out  1  result valid.
- sat_out  out  1  saturation occurred on this result; valid with strb_out.
- grow  out  1  sticky: some output in the current stage reached |x| >= 2^(OWL-2).
- blk_exp  out  EXPW  accumulated auto shifts since frame_start.
- busy  out  1  any valid sample in the pipeline.
- clr_err  out  1  sticky: stage_clr arrived while busy.

Behaviour:
- Reset: all pipeline valids, dout*, strb_out, sat_out, grow, blk_exp, clr_err and auto_sh are 0, and busy is 0. Reset mid-operation drops all in-flight samples; nothing emerges afterwards.
- Arithmetic:
  - Product: P_re = B_re*W_re - B_im*W_im and P_im = B_re*W_im + B_im*W_re, computed full precision.
  - Product rounding: add 2^(IWL2-2), arithmetic shift right by IWL2-1, keep IWL1+1 bits.
  - Sums: S1 = A + P, S2 = A - P, each IWL1+2 bits.
  - Shift: sh is 0, 1 or 2 (mode 0/1/2), or auto_sh for mode 3.
  - Output rounding and saturation: if sh > 0, add 2^(sh-1) then shift right by sh. Saturate to [-2^(OWL-1), 2^(OWL-1)-1]. Each saturated component sets sat_out for that sample.
- Pipeline:
  - Stage 1 registers the products, stage 2 the sums, stage 3 the shift/saturate.
  - LATENCY-3 plain delay stages follow.
  - mode and sh travel with each sample, so a mode change between samples takes effect exactly per sample.
- Timing: strb_out equals strb_in delayed by exactly LATENCY cycles. When strb_out = 0, the outputs hold their last value.
- Growth detector: when strb_out = 1 and any of the 4 outputs has its two MSBs unequal, grow becomes 1 the following cycle and stays 1 until an accepted stage_clr.
- stage_clr accepted (busy = 0):
  - auto_sh <= grow;
  - grow <= 0;
  - blk_exp <= blk_exp + grow, saturating at 2^EXPW-1.
  - A strb_in in the same cycle uses the new auto_sh.
- stage_clr while busy = 1: ignored entirely (no state change), and clr_err <= 1. clr_err is cleared only by rst.
- frame_start: blk_exp <= 0 and auto_sh <= 0. If frame_start and stage_clr are asserted in the same cycle, frame_start wins for blk_exp and auto_sh, and grow is still cleared.
- busy: OR of all pipeline valid bits. It is 1 from the cycle after strb_in until strb_out is emitted.
- Throughput: one sample per cycle, no backpressure; back-to-back strb_in is always legal.

Test Plan:
- Reset then mode 0, A = (0x1000, 0), B = (0x2000, 0), W = (0x4000, 0) -> after exactly 4 clocks: dout1 = (0x2000, 0), dout2 = (0x0000, 0), sat_out = 0, grow = 0.
- Mode 0, A = B = W = (0x7FFF, 0) -> dout1_re = 0x7FFF with sat_out = 1, dout2_re = 0x0001. Same inputs in mode 1 -> dout1_re = 0x7FFF with sat_out = 0, dout2_re = 0x0001.
- Mode 3 with auto_sh = 0, an output of 0x5000 -> grow rises the next cycle. stage_clr with busy = 0 -> grow = 0, blk_exp = 1. The next sample is shifted by 1: A = (0x0002, 0), P = 0 gives dout1_re = 0x0001.
- 16 back-to-back strb_in with alternating modes 0 and 2 -> 16 consecutive strb_out, each scaled per its own mode, and busy deasserts 4 cycles after the last strb_in.
- stage_clr while busy -> grow and blk_exp unchanged, clr_err = 1 until rst.
- rst asserted 2 cycles after a strb_in burst -> no strb_out ever emerges, all outputs 0 the next cycle. frame_start with stage_clr in the same cycle -> blk_exp = 0.

Source files
------------

// File: rtl/complex_butterfly_bfp.sv
// rtl/complex_butterfly_bfp.sv - radix-2 DIT complex butterfly, A +/- B*W, with
// per-sample scaling, saturation, growth detection and block-exponent tracking.
module complex_butterfly_bfp #(
  parameter int IWL1    = 16,
  parameter int IWL2    = 16,
  parameter int OWL     = 16,
  parameter int LATENCY = 4,
  parameter int EXPW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            strb_in,
  input  logic [1:0]      mode,
  input  logic [IWL1-1:0] din1_re,
  input  logic [IWL1-1:0] din1_im,
  input  logic [IWL2-1:0] din2_re,
  input  logic [IWL2-1:0] din2_im,
  input  logic [IWL1-1:0] din3_re,
  input  logic [IWL1-1:0] din3_im,
  input  logic            stage_clr,
  input  logic            frame_start,
  output logic [OWL-1:0]  dout1_re,
  output logic [OWL-1:0]  dout1_im,
  output logic [OWL-1:0]  dout2_re,
  output logic [OWL-1:0]  dout2_im,
  output logic            strb_out,
  output logic            sat_out,
  output logic            grow,
  output logic [EXPW-1:0] blk_exp,
  output logic            busy,
  output logic            clr_err
);
  localparam int PW = IWL1 + IWL2 + 1;
  localparam int QW = IWL1 + 1;
  localparam int SW = IWL1 + 2;
  localparam int RW = IWL1 + OWL + 4;
  localparam int ND = LATENCY - 2;
  localparam int OW = 4 * OWL + 1;
  localparam logic signed [PW-1:0] PRND = PW'(1) <<< (IWL2 - 2);
  localparam logic signed [RW-1:0] SMAX = (RW'(1) <<< (OWL - 1)) - RW'(1);
  localparam logic signed [RW-1:0] SMIN = -(RW'(1) <<< (OWL - 1));

  logic                   auto_sh, auto_sh_new, clr_acc, grow_hit;
  logic [1:0]             sh_in, sh1, sh2;
  logic [LATENCY-1:0]     vld;
  logic signed [PW-1:0]   br, bi, wr, wi, p1_re, p1_im;
  logic signed [IWL1-1:0] a1_re, a1_im;
  logic signed [QW-1:0]   q_re, q_im;
  logic signed [SW-1:0]   s1_re, s1_im, s2_re, s2_im;
  logic [OWL:0]           f1r, f1i, f2r, f2i;
  logic [OW-1:0]          st3_word;
  logic [OW-1:0]          ostg [ND];

  function automatic logic [OWL:0] scale_sat(input logic signed [SW-1:0] s, input logic [1:0] sh);
    logic signed [RW-1:0] x;
    x = RW'(s);
    case (sh)
      2'd1:    x = (x + RW'(1)) >>> 1;
      2'd2:    x = (x + RW'(2)) >>> 2;
      default: ;
    endcase
    if (x > SMAX) return {1'b1, OWL'(SMAX)};
    if (x < SMIN) return {1'b1, OWL'(SMIN)};
    return {1'b0, OWL'(x)};
  endfunction

  // A sample arriving with an accepted stage_clr or frame_start sees the updated auto shift.
  assign clr_acc = stage_clr && !busy;
  always_comb begin
    auto_sh_new = auto_sh;
    if (frame_start)  auto_sh_new = 1'b0;
    else if (clr_acc) auto_sh_new = grow;
    sh_in = (mode == 2'd3) ? {1'b0, auto_sh_new} : mode;
  end

  always_comb begin
    br   = PW'($signed(din1_re));
    bi   = PW'($signed(din1_im));
    wr   = PW'($signed(din2_re));
    wi   = PW'($signed(din2_im));
    q_re = QW'((p1_re + PRND) >>> (IWL2 - 1));
    q_im = QW'((p1_im + PRND) >>> (IWL2 - 1));
    f1r  = scale_sat(s1_re, sh2);
    f1i  = scale_sat(s1_im, sh2);
    f2r  = scale_sat(s2_re, sh2);
    f2i  = scale_sat(s2_im, sh2);
    st3_word = {f1r[OWL] | f1i[OWL] | f2r[OWL] | f2i[OWL],
                f1r[OWL-1:0], f1i[OWL-1:0], f2r[OWL-1:0], f2i[OWL-1:0]};
  end

  always_ff @(posedge clk) begin
    p1_re <= br * wr - bi * wi;
    p1_im <= br * wi + bi * wr;
    a1_re <= $signed(din3_re);
    a1_im <= $signed(din3_im);
    sh1   <= sh_in;
    s1_re <= SW'(a1_re) + SW'(q_re);
    s1_im <= SW'(a1_im) + SW'(q_im);
    s2_re <= SW'(a1_re) - SW'(q_re);
    s2_im <= SW'(a1_im) - SW'(q_im);
    sh2   <= sh1;
  end

  // Result stages only load on a valid sample so the outputs hold between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < ND; k++) ostg[k] <= '0;
    end else begin
      vld <= {vld[LATENCY-2:0], strb_in};
      if (vld[1]) ostg[0] <= st3_word;
      for (int k = 1; k < ND; k++)
        if (vld[k+1]) ostg[k] <= ostg[k-1];
    end
  end

  assign {sat_out, dout1_re, dout1_im, dout2_re, dout2_im} = ostg[ND-1];
  assign strb_out = vld[LATENCY-1];
  assign busy     = |vld;
  assign grow_hit = (dout1_re[OWL-1] ^ dout1_re[OWL-2]) | (dout1_im[OWL-1] ^ dout1_im[OWL-2]) |
                    (dout2_re[OWL-1] ^ dout2_re[OWL-2]) | (dout2_im[OWL-1] ^ dout2_im[OWL-2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_sh <= 1'b0;
      grow    <= 1'b0;
      blk_exp <= '0;
      clr_err <= 1'b0;
    end else begin
      auto_sh <= auto_sh_new;
      if (stage_clr && busy) clr_err <= 1'b1;
      if (clr_acc) begin
        grow <= 1'b0;
        if (grow && (blk_exp != '1)) blk_exp <= blk_exp + EXPW'(1);
      end
      if (strb_out && grow_hit) grow <= 1'b1;
      if (frame_start) blk_exp <= '0;
    end
  end
endmodule

// File: tb/tb_complex_butterfly_bfp.sv
// tb/tb_complex_butterfly_bfp.sv - scoreboard bench for complex_butterfly_bfp.
module tb_complex_butterfly_bfp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strb_in = 1'b0, stage_clr = 1'b0, frame_start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] din1_re = '0, din1_im = '0, din2_re = '0, din2_im = '0, din3_re = '0, din3_im = '0;
  logic [15:0] dout1_re, dout1_im, dout2_re, dout2_im;
  logic        strb_out, sat_out, grow, busy, clr_err;
  logic [4:0]  blk_exp;

  typedef struct {
    logic [15:0] d1r, d1i, d2r, d2i;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   err_cnt = 0;
  int   n;

  complex_butterfly_bfp dut (
    .clk(clk), .rst(rst), .strb_in(strb_in), .mode(mode),
    .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
    .din3_re(din3_re), .din3_im(din3_im), .stage_clr(stage_clr), .frame_start(frame_start),
    .dout1_re(dout1_re), .dout1_im(dout1_im), .dout2_re(dout2_re), .dout2_im(dout2_im),
    .strb_out(strb_out), .sat_out(sat_out), .grow(grow), .blk_exp(blk_exp),
    .busy(busy), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic longint wrap17(input longint v);
    if (v >= 65536)  return v - 131072;
    if (v < -65536)  return v + 131072;
    return v;
  endfunction

  function automatic logic [16:0] scale(input longint s, input int sh);
    longint v = s;
    if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(v)};
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic send(input int ar, ai, br, bi, wr, wi, input logic [1:0] md, input int esh,
                      input logic clr);
    longint pr, pi;
    logic [16:0] o1r, o1i, o2r, o2i;
    exp_t x;
    @(posedge clk); #1;
    strb_in = 1'b1; stage_clr = clr; frame_start = 1'b0; mode = md;
    din3_re = 16'(ar); din3_im = 16'(ai);
    din1_re = 16'(br); din1_im = 16'(bi);
    din2_re = 16'(wr); din2_im = 16'(wi);
    pr  = wrap17((longint'(br) * wr - longint'(bi) * wi + 16384) >>> 15);
    pi  = wrap17((longint'(br) * wi + longint'(bi) * wr + 16384) >>> 15);
    o1r = scale(ar + pr, esh);
    o1i = scale(ai + pi, esh);
    o2r = scale(ar - pr, esh);
    o2i = scale(ai - pi, esh);
    x.d1r = o1r[15:0]; x.d1i = o1i[15:0]; x.d2r = o2r[15:0]; x.d2i = o2i[15:0];
    x.sat = o1r[16] | o1i[16] | o2r[16] | o2i[16];
    x.cyc = cyc + 4;
    exp_q.push_back(x);
  endtask

  task automatic ctl(input logic clr, input logic fs);
    @(posedge clk); #1;
    strb_in = 1'b0; stage_clr = clr; frame_start = fs;
  endtask

  task automatic drain();
    repeat (7) ctl(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (strb_out) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strb_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("dout1_re", dout1_re, e.d1r);
        check_eq("dout1_im", dout1_im, e.d1i);
        check_eq("dout2_re", dout2_re, e.d2r);
        check_eq("dout2_im", dout2_im, e.d2i);
        check_eq("sat_out", sat_out, e.sat);
        check_eq("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_strb_out", strb_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grow", grow, 0);
    check_eq("rst_blk_exp", blk_exp, 0);
    check_eq("rst_clr_err", clr_err, 0);
    check_eq("rst_dout1_re", dout1_re, 0);

    send(16'h1000, 0, 16'h2000, 0, 16'h4000, 0, 2'd0, 0, 1'b0);
    drain();
    @(negedge clk);
    check_eq("t1_grow", grow, 0);

    send(32767, 0, 32767, 0, 32767, 0, 2'd0, 0, 1'b0);
    send(32767, 0, 32767, 0, 32767, 0, 2'd1, 1, 1'b0);
    drain();
    @(negedge clk);
    check_eq("t2_grow", grow, 1);

    ctl(1'b1, 1'b1);
    ctl(1'b0, 1'b0);
    @(negedge clk);
    check_eq("fs_clr_grow", grow, 0);
    check_eq("fs_clr_blk_exp", blk_exp, 0);

    send(16'h5000, 0, 0, 0, 0, 0, 2'd3, 0, 1'b0);
    drain();
    @(negedge clk);
    check_eq("auto_grow", grow, 1);
    check_eq("auto_busy", busy, 0);
    send(2, 0, 0, 0, 0, 0, 2'd3, 1, 1'b1);
    ctl(1'b0, 1'b0);
    @(negedge clk);
    check_eq("clr_grow", grow, 0);
    check_eq("clr_blk_exp", blk_exp, 1);
    drain();
    check_eq("clr_err_quiet", clr_err, 0);

    for (int i = 0; i < 16; i++)
      send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
           (i % 2 == 0) ? 2'd0 : 2'd2, (i % 2 == 0) ? 0 : 2, 1'b0);
    n = cyc;
    ctl(1'b0, 1'b0);
    while (cyc < n + 4) @(negedge clk);
    check_eq("burst_busy_hi", busy, 1);
    @(negedge clk);
    check_eq("burst_busy_lo", busy, 0);
    check_eq("burst_all_out", exp_q.size(), 0);

    ctl(1'b1, 1'b1);
    send(16'h5000, 0, 0, 0, 0, 0, 2'd0, 0, 1'b0);
    drain();
    send(16'h0100, 0, 0, 0, 0, 0, 2'd0, 0, 1'b0);
    ctl(1'b1, 1'b0);
    drain();
    @(negedge clk);
    check_eq("busy_clr_grow", grow, 1);
    check_eq("busy_clr_blk_exp", blk_exp, 0);
    check_eq("busy_clr_err", clr_err, 1);
    send(2, 0, 0, 0, 0, 0, 2'd3, 0, 1'b0);
    drain();
    check_eq("clr_err_sticky", clr_err, 1);

    send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 2'd0, 0, 1'b0);
    send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 2'd1, 1, 1'b0);
    send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 2'd2, 2, 1'b0);
    @(posedge clk); #1;
    strb_in = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_dout1_re", dout1_re, 0);
    check_eq("mid_rst_dout2_re", dout2_re, 0);
    check_eq("mid_rst_strb_out", strb_out, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_clr_err", clr_err, 0);
    drain();
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
